// File: rtl/reg_exec_seq.sv
// Execute/writeback sequencer driving both ports of a 2R1W register file.
// Single-cycle ALU ops plus an iterative shift-add multiply.
module reg_exec_seq #(
  parameter int DataWidth = 8,
  parameter int NumRegs   = 8,
  parameter int AddrWidth = $clog2(NumRegs)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [AddrWidth-1:0] rd_addr,
  input  logic [AddrWidth-1:0] rs1_addr,
  input  logic [AddrWidth-1:0] rs2_addr,
  input  logic [DataWidth-1:0] imm,
  output logic [AddrWidth-1:0] ra1,
  output logic [AddrWidth-1:0] ra2,
  input  logic [DataWidth-1:0] rd1,
  input  logic [DataWidth-1:0] rd2,
  output logic [AddrWidth-1:0] wa3,
  output logic [DataWidth-1:0] wd3,
  output logic                 we3,
  output logic                 done
);
  localparam int CntW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DataWidth - 1);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpSlt = 3'b101;
  localparam logic [2:0] OpMul = 3'b110;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [AddrWidth-1:0] rd_q, rd_d;
  logic [DataWidth-1:0] imm_q, imm_d;
  logic [AddrWidth-1:0] ra1_q, ra1_d, ra2_q, ra2_d;
  logic [DataWidth-1:0] a_q, a_d, b_q, b_d;
  logic [DataWidth-1:0] acc_q, acc_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [AddrWidth-1:0] wa3_q, wa3_d;
  logic [DataWidth-1:0] wd3_q, wd3_d;
  logic [DataWidth-1:0] alu, pp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      wa3_q   <= '0;
      wd3_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      ra1_q   <= ra1_d;
      ra2_q   <= ra2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      wa3_q   <= wa3_d;
      wd3_q   <= wd3_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    ra1_d   = ra1_q;
    ra2_d   = ra2_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    wa3_d   = wa3_q;
    wd3_d   = wd3_q;
    // partial product for the current multiplier bit
    pp  = b_q[cnt_q] ? (a_q << cnt_q) : '0;
    alu = '0;
    unique case (op_q)
      OpAdd:   alu = a_q + b_q;
      OpSub:   alu = a_q - b_q;
      OpAnd:   alu = a_q & b_q;
      OpOr:    alu = a_q | b_q;
      OpXor:   alu = a_q ^ b_q;
      OpSlt:   alu = DataWidth'(a_q < b_q);
      OpMul:   alu = acc_q + pp;
      default: alu = imm_q;
    endcase
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d    = op;
          rd_d    = rd_addr;
          imm_d   = imm;
          ra1_d   = rs1_addr;
          ra2_d   = rs2_addr;
          state_d = READ;
        end
      end
      READ: begin
        a_d     = rd1;
        b_d     = rd2;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = EXEC;
      end
      EXEC: begin
        if (op_q == OpMul && cnt_q != CntLast) begin
          acc_d = alu;
          cnt_d = cnt_q + CntW'(1);
        end else begin
          wd3_d   = alu;
          wa3_d   = rd_q;
          state_d = WB;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready = (state_q == IDLE) && reset;
  assign ra1      = ra1_q;
  assign ra2      = ra2_q;
  assign wa3      = wa3_q;
  assign wd3      = wd3_q;
  assign done     = (state_q == WB);
  assign we3      = (state_q == WB) && (rd_q != '0);

endmodule

// File: tb/tb_reg_exec_seq.sv
// Bench for reg_exec_seq: behavioural register file plus an
// instruction-level reference model of architectural register state.
module tb_reg_exec_seq;
  localparam int DW = 8;
  localparam int NR = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [AW-1:0] rd_addr, rs1_addr, rs2_addr;
  logic [DW-1:0] imm;
  logic [AW-1:0] ra1, ra2, wa3;
  logic [DW-1:0] rd1, rd2, wd3;
  logic          we3, done;

  logic [DW-1:0] rf [NR];
  int            gm [NR];
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  reg_exec_seq #(.DataWidth(DW), .NumRegs(NR)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd_addr(rd_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .imm(imm), .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2),
    .wa3(wa3), .wd3(wd3), .we3(we3), .done(done)
  );

  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];
  always @(posedge clk) if (we3) rf[wa3] <= wd3;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int model(input int o, input int a,
                               input int b, input int im);
    int r;
    case (o)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a < b) ? 1 : 0;
      6: r = a * b;
      default: r = im;
    endcase
    return r & ((1 << DW) - 1);
  endfunction

  task automatic issue(input int o, input int rd, input int s1,
                       input int s2, input int im, input bit hold);
    int c;
    int e;
    int lat;
    c = 0;
    while (!in_ready && c < 20) begin
      @(posedge clk); #1; c++;
    end
    chk("ready_idle", int'(in_ready), 1);
    op       = 3'(o);
    rd_addr  = AW'(rd);
    rs1_addr = AW'(s1);
    rs2_addr = AW'(s2);
    imm      = DW'(im);
    in_valid = 1'b1;
    e   = model(o, gm[s1], gm[s2], im);
    lat = (o == 6) ? 2 + DW : 3;
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
    c = 1;
    while (!done && c < 40) begin
      chk("busy_ready", int'(in_ready), 0);
      @(posedge clk); #1; c++;
    end
    chk("latency", c, lat);
    chk("wa3", int'(wa3), rd);
    chk("wd3", int'(wd3), e);
    chk("we3", int'(we3), (rd != 0) ? 1 : 0);
    chk("wb_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    if (rd != 0) gm[rd] = e;
    chk("rf_rd", int'(rf[rd]), gm[rd]);
    chk("rf_r0", int'(rf[0]), 0);
    chk("done_off", int'(done), 0);
    chk("we3_off", int'(we3), 0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      rf[i] = '0;
      gm[i] = 0;
    end
    reset = 1'b0;
    in_valid = 1'b0;
    op = '0; rd_addr = '0; rs1_addr = '0; rs2_addr = '0; imm = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_we3", int'(we3), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wa3", int'(wa3), 0);
    chk("rst_wd3", int'(wd3), 0);
    chk("rst_ra1", int'(ra1), 0);
    chk("rst_ra2", int'(ra2), 0);
    reset = 1'b1;
    #1;
    chk("rel_ready", int'(in_ready), 1);

    issue(7, 1, 0, 0, 10, 0);
    issue(7, 2, 0, 0, 20, 0);
    issue(0, 3, 1, 2, 0, 0);
    chk("add_30", int'(rf[3]), 30);
    issue(1, 4, 1, 2, 0, 0);
    chk("sub_f6", int'(rf[4]), 'hF6);
    issue(5, 5, 1, 2, 0, 0);
    chk("slt_1", int'(rf[5]), 1);
    issue(5, 5, 2, 1, 0, 0);
    chk("slt_0", int'(rf[5]), 0);
    issue(6, 6, 1, 2, 0, 0);
    chk("mul_c8", int'(rf[6]), 'hC8);
    issue(7, 1, 0, 0, 'h10, 0);
    issue(7, 2, 0, 0, 'h10, 0);
    issue(6, 6, 1, 2, 0, 0);
    chk("mul_wrap", int'(rf[6]), 0);
    issue(7, 0, 0, 0, 'h7B, 0);

    issue(7, 3, 0, 0, 30, 1);
    issue(0, 7, 3, 3, 0, 1);
    issue(1, 4, 7, 3, 0, 0);
    chk("fwd_60", int'(rf[7]), 60);

    issue(7, 1, 0, 0, 3, 0);
    issue(7, 2, 0, 0, 5, 0);
    op = 3'd6; rd_addr = 3'd6; rs1_addr = 3'd1; rs2_addr = 3'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_we3", int'(we3), 0);
    chk("mid_done", int'(done), 0);
    chk("mid_ready", int'(in_ready), 0);
    chk("mid_wd3", int'(wd3), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid_rel_ready", int'(in_ready), 1);
    repeat (12) @(posedge clk);
    #1;
    chk("mid_r6", int'(rf[6]), gm[6]);
    issue(0, 3, 1, 2, 0, 0);
    chk("post_add", int'(rf[3]), 8);

    for (int i = 0; i < 40; i++) begin
      issue($urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 255), (i < 39) ? bit'($urandom_range(0, 1)) : 1'b0);
    end
    for (int i = 0; i < NR; i++) chk("final_rf", int'(rf[i]), gm[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
